// File: rtl/pipe_adder.sv
// pipe_adder: pipelined adder/subtractor, carry chain cut into STAGES segments.
// One global advance moves every stage; beats leave in acceptance order.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipe_adder: STAGES must lie in 1..WIDTH");
  end

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  // Per-stage state. opa/opb keep only the bits still to be added,
  // sum keeps only the bits already produced.
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;
  logic [SEG:0]     r;
  logic             top_a;
  logic             top_b;
  logic             top_s;

  // One segment of the carry chain: returns {carry_out, sum_seg}.
  function automatic logic [SEG:0] seg_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin,
    input int               k
  );
    logic [SEG:0] xs;
    logic [SEG:0] ys;
    xs = {1'b0, x[k*SEG +: SEG]};
    ys = {1'b0, y[k*SEG +: SEG]};
    seg_add = xs + ys + {{SEG{1'b0}}, cin};
  endfunction

  // Mask selecting operand bits above segment k.
  function automatic logic [WIDTH-1:0] hi_mask(input int k);
    logic [WIDTH-1:0] m;
    m = {WIDTH{1'b1}};
    hi_mask = m << ((k + 1) * SEG);
  endfunction

  // Subtract as a + ~b + 1; carry-in is forced high.
  always_comb begin
    b_eff  = sub ? ~b : b;
    ci_eff = sub | ci;
  end

  // Global advance: pipeline moves unless the output is stalled.
  always_comb begin
    adv = !v_q[STAGES-1] || out_ready;
  end

  // Segment adders and skew bookkeeping for every stage.
  always_comb begin
    r     = seg_add(a, b_eff, ci_eff, 0);
    top_a = a[WIDTH-1];
    top_b = b_eff[WIDTH-1];
    top_s = r[SEG-1];

    v_d[0]              = in_valid;
    c_d[0]              = r[SEG];
    opa_d[0]            = a & hi_mask(0);
    opb_d[0]            = b_eff & hi_mask(0);
    sum_d[0]            = '0;
    sum_d[0][SEG-1:0]   = r[SEG-1:0];

    for (int k = 1; k < STAGES; k++) begin
      r     = seg_add(opa_q[k-1], opb_q[k-1], c_q[k-1], k);
      top_a = opa_q[k-1][WIDTH-1];
      top_b = opb_q[k-1][WIDTH-1];
      top_s = r[SEG-1];

      v_d[k]                  = v_q[k-1];
      c_d[k]                  = r[SEG];
      opa_d[k]                = opa_q[k-1] & hi_mask(k);
      opb_d[k]                = opb_q[k-1] & hi_mask(k);
      sum_d[k]                = sum_q[k-1];
      sum_d[k][k*SEG +: SEG]  = r[SEG-1:0];
    end

    ovf_d = (top_a == top_b) && (top_s != top_a);
  end

  // Stage registers: cleared by reset, shifted together on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_d[k];
        c_q[k]   <= c_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // A stalled output beat must not change until it is taken.
  property p_hold;
    @(posedge clk) disable iff (rst)
      out_valid && !out_ready |=>
        out_valid && $stable(s) && $stable(co) && $stable(ovf);
  endproperty

  a_hold: assert property (p_hold);

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined adder/subtractor with valid/ready handshake. The WIDTH-bit carry chain is split into STAGES equal segments, and a register sits between segments, so clock frequency scales with segment width rather than full width. It adds subtract mode, signed-overflow detection and backpressure. It serves as the arithmetic core for datapath blocks that need throughput of one operation per clock at 32 bits and wider.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments, 1..WIDTH; segment width SEG = WIDTH/STAGES.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry in; ignored when sub=1.
- sub  in  1  0: s=a+b+ci; 1: s=a-b.
- out_valid  out  1  result beat presented.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- co  out  1  carry out; in subtract mode 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Subtract is computed as a + ~b + 1. Operand B is inverted and the carry-in is forced to 1 at stage 0.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and the effective b, plus the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Skew registers:
  - Operand bits above segment k are carried forward so each segment sees its own inputs in its own stage.
  - Sum bits below segment k are carried forward so all WIDTH bits of s emerge together.
- co is the carry out of bit WIDTH-1.
- ovf = (A[W-1] == B'[W-1]) && (s[W-1] != A[W-1]), where B' is the effective (possibly inverted) operand B.
- Each stage holds a valid bit. There is one global advance signal: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts forward one position.
  - When adv=0, all stage registers and valid bits hold.
- in_ready = adv.
- A beat is accepted when in_valid && in_ready. When in_valid=0 and adv=1, a bubble (valid=0) enters stage 0.
- Internal bubbles are not collapsed.
- Beats leave in acceptance order; none is dropped or duplicated.
- An output beat transfers when out_valid && out_ready.
- STAGES=1 degenerates to a single registered full-width adder with the same handshake.
- Parameter check: WIDTH % STAGES != 0 is an elaboration error.

## Timing
- Reset (async, immediate): all valid bits = 0, out_valid=0, s=0, co=0, ovf=0. All skew and carry registers clear to 0.
- in_ready is combinational from out_valid and out_ready. It is 1 immediately after reset is released.
- Latency: a beat accepted in cycle t is presented in cycle t+STAGES when no stall occurs. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, s, co and ovf hold stable and in_ready=0.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- Reset asserted mid-stream discards all in-flight beats. No stale beat appears after reset is released.
- s, co and ovf are don't-care when out_valid=0. The bench checks them only on valid beats.

## Test plan
All scenarios use WIDTH=32, STAGES=4 unless stated otherwise.
1. Full carry ripple: a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0, accepted in cycle t -> out_valid in cycle t+4 with s=0x00000000, co=1, ovf=0.
2. Signed overflow on add: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ovf=1. Then a=0x00000001, b=0x00000002, ci=1 -> s=0x00000004, co=0, ovf=0.
3. Subtract:
   - a=5, b=7, sub=1, ci=1 (ignored) -> s=0xFFFFFFFE, co=0, ovf=0.
   - a=0x80000000, b=1, sub=1 -> s=0x7FFFFFFF, co=1, ovf=1.
4. Backpressure: 8 back-to-back random beats, with out_ready=0 for 3 cycles starting at the first valid output.
   - in_ready=0 exactly during those cycles.
   - All 8 results match the reference model, in order, with no loss or duplication.
   - Held outputs stay stable during the stall.
5. Reset mid-stream: 3 beats in flight, rst pulsed for 1 cycle.
   - out_valid=0 asynchronously.
   - No output beat appears in the following 6 cycles with in_valid=0.
   - The next accepted beat returns correctly after 4 cycles.
6. Degenerate config WIDTH=8, STAGES=1: a=0xF0, b=0x10, ci=1 -> s=0x01, co=1, ovf=0, presented 1 cycle after acceptance.
